// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: funct3 codes, CSR map and WARL masks.
package csr_pkg;

  // funct3 encodings of the Zicsr instructions
  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  // CSR addresses
  localparam logic [11:0] CSR_MTVEC        = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
  localparam logic [11:0] CSR_MEPC         = 12'h341;
  localparam logic [11:0] CSR_MCAUSE       = 12'h342;
  localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;
  localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH      = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH    = 12'hB82;
  localparam logic [11:0] CSR_CYCLE        = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
  localparam logic [11:0] CSR_INSTRET      = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH     = 12'hC82;
  localparam logic [11:0] CSR_MHARTID      = 12'hF14;

  // WARL write masks: mtvec bit1 is hardwired to 0, mepc is 4-byte aligned
  localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK  = 32'hFFFF_FFFC;

  // Addresses with bits [11:10] == 2'b11 are read-only; writing them is illegal
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independent 32-bit half writes that take precedence over the increment.
module csr_counter64
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] value_q;
  logic [63:0] value_d;

  // Next count: any half write freezes the whole counter for this cycle, the other half holds
  always_comb begin
    value_d = value_q;
    if (wr_lo || wr_hi) begin
      value_d[31:0]  = wr_lo ? wdata : value_q[31:0];
      value_d[63:32] = wr_hi ? wdata : value_q[63:32];
    end else if (inc) begin
      value_d = value_q + 64'd1;
    end else begin
      value_d = value_q;
    end
  end

  // Counter register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= 64'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: atomic CSR read-modify-write with a one-cycle registered response.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          NUM_SCRATCH = 4,
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [2:0]      req_funct,
  input  logic [11:0]     req_addr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic            retire,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal
);

  localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
  localparam logic [XLEN-1:0] MTVEC_RST = {MTVEC_RESET[XLEN-1:2], 1'b0, MTVEC_RESET[0]};

  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] scr_q [SCR_N];
  logic [XLEN-1:0] scr_d [SCR_N];
  logic [SCR_N-1:0] scr_sel_s;
  logic            scr_hit_s;
  logic [XLEN-1:0] scr_rdata_s;
  logic [63:0]     cycle_s, instret_s;
  logic            hit_s, illegal_s, wr_intent_s, do_write_s;
  logic [XLEN-1:0] src_s, old_s, wdata_s;
  logic            resp_valid_q, resp_valid_d, resp_illegal_q, resp_illegal_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;

  // Scratch address decode, one selector per implemented scratch register
  always_comb begin
    scr_sel_s   = '0;
    scr_hit_s   = 1'b0;
    scr_rdata_s = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (req_addr == (CSR_SCRATCH_BASE + 12'(i))) begin
        scr_sel_s[i] = 1'b1;
        scr_hit_s    = 1'b1;
        scr_rdata_s  = scr_q[i];
      end else begin
        scr_sel_s[i] = 1'b0;
      end
    end
  end

  // Read mux: current CSR value and whether the address is mapped at all
  always_comb begin
    hit_s = 1'b1;
    old_s = '0;
    case (req_addr)
      CSR_MTVEC:                 old_s = mtvec_q;
      CSR_MSCRATCH:              old_s = mscratch_q;
      CSR_MEPC:                  old_s = mepc_q;
      CSR_MCAUSE:                old_s = mcause_q;
      CSR_MCYCLE,   CSR_CYCLE:   old_s = cycle_s[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:  old_s = cycle_s[63:32];
      CSR_MINSTRET, CSR_INSTRET: old_s = instret_s[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_s = instret_s[63:32];
      CSR_MHARTID:               old_s = HART_ID;
      default: begin
        hit_s = scr_hit_s;
        old_s = scr_rdata_s;
      end
    endcase
  end

  // Operation decode: source operand, write intent, legality and the new value
  always_comb begin
    src_s       = req_funct[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_val;
    wr_intent_s = (req_funct[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
    illegal_s   = !hit_s || (req_funct[1:0] == 2'b00) ||
                  (wr_intent_s && csr_is_read_only(req_addr));
    do_write_s  = req_valid && !illegal_s && wr_intent_s;
    case (req_funct[1:0])
      2'b01:   wdata_s = src_s;
      2'b10:   wdata_s = old_s | src_s;
      2'b11:   wdata_s = old_s & ~src_s;
      default: wdata_s = old_s;
    endcase
  end

  // Next state of the plain CSRs, with WARL masking applied on write
  always_comb begin
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (do_write_s) begin
      case (req_addr)
        CSR_MTVEC:    mtvec_d    = wdata_s & MTVEC_WMASK;
        CSR_MSCRATCH: mscratch_d = wdata_s;
        CSR_MEPC:     mepc_d     = wdata_s & MEPC_WMASK;
        CSR_MCAUSE:   mcause_d   = wdata_s;
        default:      mtvec_d    = mtvec_q;
      endcase
    end else begin
      mtvec_d = mtvec_q;
    end
    for (int i = 0; i < SCR_N; i++) begin
      scr_d[i] = (do_write_s && scr_sel_s[i]) ? wdata_s : scr_q[i];
    end
  end

  // Response: old value for legal requests, zero data when illegal or idle
  always_comb begin
    resp_valid_d   = req_valid;
    resp_illegal_d = req_valid && illegal_s;
    if (req_valid && !illegal_s) begin
      resp_rdata_d = old_s;
    end else begin
      resp_rdata_d = '0;
    end
  end

  // CSR state and response registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      for (int i = 0; i < SCR_N; i++) scr_q[i] <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_illegal_q <= 1'b0;
    end else begin
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      for (int i = 0; i < SCR_N; i++) scr_q[i] <= scr_d[i];
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
    end
  end

  csr_counter64 u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (do_write_s && (req_addr == CSR_MCYCLE)),
    .wr_hi (do_write_s && (req_addr == CSR_MCYCLEH)),
    .wdata (wdata_s),
    .value (cycle_s)
  );

  csr_counter64 u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .wr_lo (do_write_s && (req_addr == CSR_MINSTRET)),
    .wr_hi (do_write_s && (req_addr == CSR_MINSTRETH)),
    .wdata (wdata_s),
    .value (instret_s)
  );

  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: vector table plus counter/reset sequences, scoreboard-checked.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_funct = 3'b000;
  logic [11:0] req_addr = 12'h000;
  logic [4:0]  req_rs1_idx = 5'd0;
  logic [31:0] req_rs1_val = 32'h0;
  logic        retire = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_illegal;

  csr_unit #(
    .XLEN(32), .NUM_SCRATCH(4), .HART_ID(32'h0000_0005), .MTVEC_RESET(32'h8000_0103)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_funct(req_funct),
    .req_addr(req_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_val(req_rs1_val),
    .retire(retire), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic        valid;
    logic [31:0] rdata;
    logic        ill;
    logic        full;
    string       name;
  } sb_t;

  typedef struct {
    logic [2:0]  funct;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [31:0] val;
    logic [31:0] exp;
    logic        ill;
    string       name;
  } vec_t;

  sb_t         sb_q[$];
  sb_t         chk_e;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [63:0] mc_m = 64'd0;
  logic [63:0] mi_m = 64'd0;
  vec_t        vecs[24];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard checker: compare each expected response in the cycle it is due
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      chk_e = sb_q.pop_front();
      total++;
      if (resp_valid !== chk_e.valid ||
          ((chk_e.valid || chk_e.full) &&
           (resp_rdata !== chk_e.rdata || resp_illegal !== chk_e.ill))) begin
        bad++;
        $display("FAIL %s: got valid=%0b rdata=%h illegal=%0b, want valid=%0b rdata=%h illegal=%0b",
                 chk_e.name, resp_valid, resp_rdata, resp_illegal,
                 chk_e.valid, chk_e.rdata, chk_e.ill);
      end
    end
  end

  function automatic logic [31:0] rmw(input logic [2:0] f, input logic [31:0] o, input logic [31:0] s);
    case (f[1:0])
      2'b01:   return s;
      2'b10:   return o | s;
      2'b11:   return o & ~s;
      default: return o;
    endcase
  endfunction

  // One request cycle: drive, queue the expectation, advance the counter model
  task automatic step(input logic v, input logic [2:0] f, input logic [11:0] a,
                      input logic [4:0] idx, input logic [31:0] val, input logic ret,
                      input logic ill, input logic [31:0] exp, input string nm);
    sb_t e;
    logic wr;
    logic [31:0] src;
    req_valid = v; req_funct = f; req_addr = a; req_rs1_idx = idx;
    req_rs1_val = val; retire = ret;
    e.due = cyc + 1; e.valid = v; e.rdata = exp; e.ill = ill; e.full = 1'b0; e.name = nm;
    sb_q.push_back(e);
    wr  = v && !ill && (f[1:0] == 2'b01 || idx != 5'd0);
    src = f[2] ? {27'd0, idx} : val;
    if (wr && a == CSR_MCYCLE)       mc_m[31:0]  = rmw(f, mc_m[31:0], src);
    else if (wr && a == CSR_MCYCLEH) mc_m[63:32] = rmw(f, mc_m[63:32], src);
    else                             mc_m        = mc_m + 64'd1;
    if (wr && a == CSR_MINSTRET)       mi_m[31:0]  = rmw(f, mi_m[31:0], src);
    else if (wr && a == CSR_MINSTRETH) mi_m[63:32] = rmw(f, mi_m[63:32], src);
    else if (ret)                      mi_m        = mi_m + 64'd1;
    @(posedge clk); #1;
  endtask

  // Reset cycle with a live request that must be discarded
  task automatic reset_cycle(input string nm);
    sb_t e;
    rst_n = 1'b0; req_valid = 1'b1; req_funct = CSRRW; req_addr = CSR_MSCRATCH;
    req_rs1_idx = 5'd1; req_rs1_val = 32'h0000_0777; retire = 1'b1;
    e.due = cyc + 1; e.valid = 1'b0; e.rdata = 32'h0; e.ill = 1'b0; e.full = 1'b1; e.name = nm;
    sb_q.push_back(e);
    mc_m = 64'd0; mi_m = 64'd0;
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0; retire = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{CSRRW,  12'h340, 5'd1,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "mscratch_rw"};
    vecs[1]  = '{CSRRS,  12'h340, 5'd1,  32'h0000_00F0, 32'hDEAD_BEEF, 1'b0, "mscratch_rs"};
    vecs[2]  = '{CSRRCI, 12'h340, 5'd15, 32'h0,         32'hDEAD_BEFF, 1'b0, "mscratch_rci"};
    vecs[3]  = '{CSRRS,  12'h340, 5'd0,  32'h0,         32'hDEAD_BEF0, 1'b0, "mscratch_rd"};
    vecs[4]  = '{CSRRS,  12'h305, 5'd0,  32'h0,         32'h8000_0101, 1'b0, "mtvec_reset"};
    vecs[5]  = '{CSRRW,  12'h305, 5'd1,  32'hFFFF_FFFF, 32'h8000_0101, 1'b0, "mtvec_wr"};
    vecs[6]  = '{CSRRS,  12'h305, 5'd0,  32'h0,         32'hFFFF_FFFD, 1'b0, "mtvec_warl"};
    vecs[7]  = '{CSRRW,  12'h341, 5'd1,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mepc_wr"};
    vecs[8]  = '{CSRRS,  12'h341, 5'd0,  32'h0,         32'hFFFF_FFFC, 1'b0, "mepc_warl"};
    vecs[9]  = '{CSRRS,  12'hF14, 5'd0,  32'h0,         32'h0000_0005, 1'b0, "mhartid"};
    vecs[10] = '{CSRRW,  12'hF14, 5'd1,  32'h1,         32'h0000_0000, 1'b1, "mhartid_wr"};
    vecs[11] = '{CSRRWI, 12'h342, 5'd31, 32'h0,         32'h0000_0000, 1'b0, "mcause_rwi"};
    vecs[12] = '{CSRRSI, 12'h342, 5'd0,  32'h0,         32'h0000_001F, 1'b0, "mcause_rd"};
    vecs[13] = '{CSRRW,  12'h7C3, 5'd1,  32'h0000_A5A5, 32'h0000_0000, 1'b0, "scr3_wr"};
    vecs[14] = '{CSRRS,  12'h7C3, 5'd0,  32'h0,         32'h0000_A5A5, 1'b0, "scr3_rd"};
    vecs[15] = '{CSRRW,  12'h7C4, 5'd1,  32'h1,         32'h0000_0000, 1'b1, "scr_oob"};
    vecs[16] = '{3'b100, 12'h340, 5'd1,  32'h1,         32'h0000_0000, 1'b1, "funct100"};
    vecs[17] = '{3'b000, 12'h340, 5'd1,  32'h1,         32'h0000_0000, 1'b1, "funct000"};
    vecs[18] = '{CSRRS,  12'h340, 5'd0,  32'h0,         32'hDEAD_BEF0, 1'b0, "mscratch_kept"};
    vecs[19] = '{CSRRS,  12'h123, 5'd0,  32'h0,         32'h0000_0000, 1'b1, "unmapped"};
    vecs[20] = '{CSRRC,  12'h340, 5'd2,  32'hFFFF_0000, 32'hDEAD_BEF0, 1'b0, "mscratch_rc"};
    vecs[21] = '{CSRRS,  12'h340, 5'd0,  32'h0,         32'h0000_BEF0, 1'b0, "mscratch_rc_rd"};
    vecs[22] = '{CSRRW,  12'h7C0, 5'd1,  32'h0000_0001, 32'h0000_0000, 1'b0, "scr0_wr"};
    vecs[23] = '{CSRRCI, 12'hF14, 5'd0,  32'h0,         32'h0000_0005, 1'b0, "ro_suppressed"};

    reset_cycle("reset0");
    reset_cycle("reset1");
    step(1'b1, CSRRS, CSR_MCYCLE, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "mcycle_first");

    foreach (vecs[i])
      step(1'b1, vecs[i].funct, vecs[i].addr, vecs[i].idx, vecs[i].val, 1'b0,
           vecs[i].ill, vecs[i].exp, vecs[i].name);

    // read-only counter aliases
    step(1'b1, CSRRS, CSR_CYCLE, 5'd0, 32'h0, 1'b0, 1'b0, mc_m[31:0], "cycle_rd");
    step(1'b1, CSRRW, CSR_CYCLE, 5'd1, 32'h1234, 1'b0, 1'b1, 32'h0, "cycle_wr_ill");
    step(1'b1, CSRRS, CSR_CYCLE, 5'd0, 32'h0, 1'b0, 1'b0, mc_m[31:0], "cycle_after_ill");

    // low-half carry into mcycleh
    step(1'b1, CSRRW, CSR_MCYCLEH, 5'd1, 32'h0, 1'b0, 1'b0, mc_m[63:32], "mcycleh_clr");
    step(1'b1, CSRRW, CSR_MCYCLE, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, mc_m[31:0], "mcycle_max");
    step(1'b1, CSRRS, CSR_MCYCLEH, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "mcycleh_pre");
    step(1'b1, CSRRS, CSR_MCYCLEH, 5'd0, 32'h0, 1'b0, 1'b0, 32'h1, "mcycleh_carry");

    // write beats increment; unwritten half holds
    step(1'b1, CSRRW, CSR_MCYCLEH, 5'd1, 32'h12, 1'b0, 1'b0, 32'h1, "mcycleh_wr");
    step(1'b1, CSRRW, CSR_MCYCLE, 5'd1, 32'h5, 1'b0, 1'b0, mc_m[31:0], "mcycle_wr5");
    step(1'b1, CSRRS, CSR_MCYCLE, 5'd0, 32'h0, 1'b0, 1'b0, 32'h5, "mcycle_is5");
    step(1'b1, CSRRS, CSR_MCYCLEH, 5'd0, 32'h0, 1'b0, 1'b0, 32'h12, "mcycleh_held");

    // retire counting and write-over-retire
    step(1'b1, CSRRW, CSR_MINSTRET, 5'd1, 32'h0, 1'b0, 1'b0, mi_m[31:0], "minstret_clr");
    step(1'b1, CSRRW, CSR_MINSTRETH, 5'd1, 32'h0, 1'b0, 1'b0, mi_m[63:32], "minstreth_clr");
    for (int k = 0; k < 10; k++)
      step(1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, "idle_retire");
    step(1'b1, CSRRS, CSR_MINSTRET, 5'd0, 32'h0, 1'b0, 1'b0, 32'd10, "minstret_10");
    step(1'b1, CSRRW, CSR_MINSTRET, 5'd1, 32'd100, 1'b1, 1'b0, 32'd10, "minstret_wr100");
    step(1'b1, CSRRS, CSR_MINSTRET, 5'd0, 32'h0, 1'b0, 1'b0, 32'd100, "minstret_100");
    step(1'b1, CSRRS, CSR_INSTRET, 5'd0, 32'h0, 1'b0, 1'b0, 32'd100, "instret_alias");
    step(1'b1, CSRRS, CSR_INSTRETH, 5'd0, 32'h0, 1'b0, 1'b0, 32'd0, "instreth_alias");

    // mid-stream reset with a live request
    step(1'b1, CSRRW, CSR_MSCRATCH, 5'd1, 32'h1357_9BDF, 1'b0, 1'b0, 32'h0000_BEF0, "pre_reset_wr");
    reset_cycle("midreset");
    step(1'b1, CSRRS, CSR_MCYCLE, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "rst_mcycle");
    step(1'b1, CSRRS, CSR_MSCRATCH, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "rst_mscratch");
    step(1'b1, CSRRS, CSR_MEPC, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "rst_mepc");
    step(1'b1, CSRRS, CSR_MCAUSE, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "rst_mcause");
    step(1'b1, CSRRS, 12'h7C3, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "rst_scr3");
    step(1'b1, CSRRS, CSR_MTVEC, 5'd0, 32'h0, 1'b0, 1'b0, 32'h8000_0101, "rst_mtvec");
    step(1'b1, CSRRS, CSR_MINSTRET, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "rst_minstret");
    step(1'b1, CSRRS, CSR_MCYCLEH, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "rst_mcycleh");
    step(1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, "idle_end");

    @(negedge clk); @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
